// File: rtl/ocs_pkg.sv
// Shared constants, FSM state and Benes wiring for the grant checker.
// The fabric is 8 lines through 5 switch columns of 4 two-by-two switches each.
package ocs_pkg;
  localparam int PORTNUM    = 8;
  localparam int DSTWIDTH   = 3;
  localparam int STAGENUM   = 5;
  localparam int SWITCHNUM  = 4;
  localparam int REQWIDTH   = PORTNUM * DSTWIDTH;
  localparam int GRANTWIDTH = STAGENUM * SWITCHNUM;

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    CHECK
  } state_t;

  typedef logic [PORTNUM-1:0][DSTWIDTH-1:0] tag_vec_t;

  // Entry l holds the line that line l is wired to after the given stage.
  // Stage 0 rotates the line index right, stage 3 rotates it left.
  // Stages 1 and 2 swap the two low bits inside each half.
  // Stage 4 is the output column and has no wiring.
  function automatic tag_vec_t stage_wiring(input logic [2:0] stage);
    tag_vec_t   w;
    logic [2:0] ln;
    w = '0;
    for (int l = 0; l < PORTNUM; l++) begin
      ln = 3'(l);
      case (stage)
        3'd0:    w[l] = {ln[0], ln[2], ln[1]};
        3'd1,
        3'd2:    w[l] = {ln[2], ln[0], ln[1]};
        3'd3:    w[l] = {ln[1], ln[0], ln[2]};
        default: w[l] = ln;
      endcase
    end
    return w;
  endfunction
endpackage

// File: rtl/ocs_grant_checker_if.sv
// Request/grant inputs and result outputs of the grant checker.
// The master drives the i_* signals and the checker (slave) drives the o_* signals.
interface ocs_grant_checker_if #(
  parameter int P_CNTWIDTH = 16
) ();
  import ocs_pkg::*;

  // i_req_valid and i_grant_valid are single-cycle strobes with no ready.
  // A grant that arrives while the checker is busy is dropped and flagged in o_overrun.
  // o_result_valid is a single-cycle pulse.
  // o_pass, o_err_port and o_perm keep their values until the next pulse.
  logic [REQWIDTH-1:0]   i_req;
  logic                  i_req_valid;
  logic [GRANTWIDTH-1:0] i_grant;
  logic                  i_grant_valid;
  logic                  o_busy;
  logic                  o_result_valid;
  logic                  o_pass;
  logic [DSTWIDTH-1:0]   o_err_port;
  logic [REQWIDTH-1:0]   o_perm;
  logic [P_CNTWIDTH-1:0] o_test_cnt;
  logic [P_CNTWIDTH-1:0] o_err_cnt;
  logic                  o_overrun;
  state_t                dbg_state;

  modport master (
    output i_req, i_req_valid, i_grant, i_grant_valid,
    input  o_busy, o_result_valid, o_pass, o_err_port, o_perm,
    input  o_test_cnt, o_err_cnt, o_overrun, dbg_state
  );

  modport slave (
    input  i_req, i_req_valid, i_grant, i_grant_valid,
    output o_busy, o_result_valid, o_pass, o_err_port, o_perm,
    output o_test_cnt, o_err_cnt, o_overrun, dbg_state
  );
endinterface

// File: rtl/ocs_benes_stage.sv
// One Benes switch column followed by its inter-stage wiring.
// This block is purely combinational; the stage index selects which wiring is applied.
module ocs_benes_stage
  import ocs_pkg::*;
#(
  parameter logic P_CROSS = 1'b1
) (
  input  tag_vec_t             tag_in,
  input  logic [SWITCHNUM-1:0] sw,
  input  logic [2:0]           stage,
  output tag_vec_t             tag_out
);
  tag_vec_t swapped;
  tag_vec_t wiring;

  always_comb begin
    swapped = tag_in;
    for (int k = 0; k < SWITCHNUM; k++) begin
      if (sw[k] == P_CROSS) begin
        swapped[2*k]   = tag_in[2*k+1];
        swapped[2*k+1] = tag_in[2*k];
      end
    end
  end

  // The wiring is a bijection, so every output entry is overwritten exactly once.
  always_comb begin
    wiring  = stage_wiring(stage);
    tag_out = swapped;
    for (int l = 0; l < PORTNUM; l++) begin
      tag_out[wiring[l]] = swapped[l];
    end
  end
endmodule

// File: rtl/ocs_grant_checker.sv
// Traces an 8x8 Benes grant one stage per cycle.
// It then verifies the realised permutation against the captured request, one output line per cycle.
module ocs_grant_checker
  import ocs_pkg::*;
#(
  parameter logic P_BAR      = 1'b0,
  parameter logic P_CROSS    = 1'b1,
  parameter int   P_CNTWIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  ocs_grant_checker_if.slave bus
);
  state_t                state_q, state_d;
  tag_vec_t              req_slot_q, req_copy_q, tag_q, tag_next;
  tag_vec_t              perm_work_q, perm_next, perm_q;
  logic [GRANTWIDTH-1:0] grant_q;
  logic [SWITCHNUM-1:0]  stage_sw;
  logic [2:0]            stage_q, line_q, first_err_q, err_port_q, cur_src;
  logic                  pending_q, mis_q, pass_q, result_valid_q, overrun_q;
  logic                  busy, start, orphan, cur_mis, last_check;
  logic [P_CNTWIDTH-1:0] test_cnt_q, err_cnt_q;

  assign stage_sw = grant_q[SWITCHNUM*stage_q +: SWITCHNUM];

  ocs_benes_stage #(.P_CROSS(P_CROSS)) u_stage (
    .tag_in  (tag_q),
    .sw      (stage_sw),
    .stage   (stage_q),
    .tag_out (tag_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ROUTE;
      ROUTE:   if (stage_q == 3'(STAGENUM-1)) state_d = CHECK;
      CHECK:   if (last_check) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A request that arrives in the same cycle as the grant counts as pending.
  always_comb begin
    busy       = (state_q != IDLE);
    start      = (state_q == IDLE) && bus.i_grant_valid && (pending_q || bus.i_req_valid);
    orphan     = (state_q == IDLE) && bus.i_grant_valid && !pending_q && !bus.i_req_valid;
    last_check = (state_q == CHECK) && (line_q == 3'(PORTNUM-1));
    cur_src    = tag_q[line_q];
    cur_mis    = (req_copy_q[cur_src] != line_q);
    perm_next  = perm_work_q;
    perm_next[cur_src] = line_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_slot_q     <= '0;
      req_copy_q     <= '0;
      pending_q      <= 1'b0;
      grant_q        <= {GRANTWIDTH{P_BAR}};
      tag_q          <= '0;
      stage_q        <= '0;
      line_q         <= '0;
      mis_q          <= 1'b0;
      first_err_q    <= '0;
      perm_work_q    <= '0;
      perm_q         <= '0;
      pass_q         <= 1'b0;
      err_port_q     <= '0;
      result_valid_q <= 1'b0;
      test_cnt_q     <= '0;
      err_cnt_q      <= '0;
      overrun_q      <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (bus.i_req_valid) req_slot_q <= bus.i_req;
      if (start)                pending_q <= 1'b0;
      else if (bus.i_req_valid) pending_q <= 1'b1;
      if (bus.i_grant_valid && busy) overrun_q <= 1'b1;
      if (orphan && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (start) begin
            req_copy_q <= bus.i_req_valid ? bus.i_req : req_slot_q;
            grant_q    <= bus.i_grant;
            stage_q    <= '0;
            for (int j = 0; j < PORTNUM; j++) tag_q[j] <= 3'(j);
          end
        end
        ROUTE: begin
          tag_q       <= tag_next;
          stage_q     <= stage_q + 3'd1;
          line_q      <= '0;
          mis_q       <= 1'b0;
          first_err_q <= '0;
          perm_work_q <= '0;
        end
        CHECK: begin
          perm_work_q <= perm_next;
          line_q      <= line_q + 3'd1;
          if (cur_mis && !mis_q) begin
            mis_q       <= 1'b1;
            first_err_q <= line_q;
          end
          if (last_check) begin
            result_valid_q <= 1'b1;
            pass_q         <= !(mis_q || cur_mis);
            err_port_q     <= mis_q ? first_err_q : (cur_mis ? line_q : 3'd0);
            perm_q         <= perm_next;
            test_cnt_q     <= test_cnt_q + 1'b1;
            if ((mis_q || cur_mis) && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy         = busy;
  assign bus.o_result_valid = result_valid_q;
  assign bus.o_pass         = pass_q;
  assign bus.o_err_port     = err_port_q;
  assign bus.o_perm         = perm_q;
  assign bus.o_test_cnt     = test_cnt_q;
  assign bus.o_err_cnt      = err_cnt_q;
  assign bus.o_overrun      = overrun_q;
  assign bus.dbg_state      = state_q;
endmodule

// File: tb/tb_ocs_grant_checker.sv
// Directed bench for ocs_grant_checker.
// A path-tracing reference model is checked against the DUT every cycle, with literal expectations at key points.
module tb_ocs_grant_checker;
  import ocs_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ocs_grant_checker_if #(.P_CNTWIDTH(16)) bus ();

  ocs_grant_checker #(.P_BAR(1'b0), .P_CROSS(1'b1), .P_CNTWIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: values the DUT outputs must show after the latest edge.
  logic        m_busy = 0, m_rv = 0, m_pend = 0, m_pass = 0, m_ovr = 0;
  logic [2:0]  m_port = 0;
  logic [23:0] m_perm = 0, m_slot = 0;
  logic [15:0] m_test = 0, m_err = 0;
  int          cyc = 0, m_done = 0;
  logic        sat_err_flag = 0, wrap_test_flag = 0;
  logic [27:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Follow each input port through the fabric.
  // Result packing: {pass, lowest bad output line, realised permutation}.
  function automatic logic [27:0] model_result(input logic [23:0] r, input logic [19:0] g);
    logic [23:0] perm;
    logic [2:0]  port;
    logic        found;
    int          p;
    perm = '0;
    for (int i = 0; i < 8; i++) begin
      p = i;
      for (int s = 0; s < 5; s++) begin
        if (g[4*s + p/2]) p = p ^ 1;
        case (s)
          0:       p = (p % 2) * 4 + p / 2;
          1, 2:    p = (p / 4) * 4 + ((p % 4) % 2) * 2 + (p % 4) / 2;
          3:       p = (p < 4) ? 2 * p : 2 * (p - 4) + 1;
          default: ;
        endcase
      end
      perm[3*i +: 3] = 3'(p);
    end
    port  = '0;
    found = 1'b0;
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 8; i++)
        if (!found && perm[3*i +: 3] == 3'(j) && r[3*i +: 3] != 3'(j)) begin
          found = 1'b1;
          port  = 3'(j);
        end
    return {!found, port, perm};
  endfunction

  initial begin
    logic        was_busy, accepted;
    logic [27:0] res;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 0; m_rv = 0; m_pend = 0; m_pass = 0; m_ovr = 0;
        m_port = 0; m_perm = 0; m_slot = 0; m_test = 0; m_err = 0;
        exp_q.delete();
      end else begin
        cyc++;
        if (sat_err_flag)   m_err  = 16'hFFFF;
        if (wrap_test_flag) m_test = 16'hFFFF;
        was_busy = m_busy;
        accepted = 1'b0;
        m_rv     = 1'b0;
        if (was_busy && bus.i_grant_valid) m_ovr = 1'b1;
        if (was_busy && cyc == m_done) begin
          res    = (exp_q.size() != 0) ? exp_q.pop_front() : 28'h0;
          m_rv   = 1'b1;
          m_pass = res[27];
          m_port = res[26:24];
          m_perm = res[23:0];
          m_busy = 1'b0;
          m_test = m_test + 16'd1;
          if (!m_pass && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        end
        if (!was_busy && bus.i_grant_valid) begin
          if (m_pend || bus.i_req_valid) begin
            exp_q.push_back(model_result(bus.i_req_valid ? bus.i_req : m_slot, bus.i_grant));
            m_busy   = 1'b1;
            m_done   = cyc + 13;
            m_pend   = 1'b0;
            accepted = 1'b1;
          end else if (m_err != 16'hFFFF) begin
            m_err = m_err + 16'd1;
          end
        end
        if (bus.i_req_valid) begin
          m_slot = bus.i_req;
          if (!accepted) m_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("busy",         32'(bus.o_busy),         32'(m_busy));
        chk("result_valid", 32'(bus.o_result_valid), 32'(m_rv));
        chk("pass",         32'(bus.o_pass),         32'(m_pass));
        chk("err_port",     32'(bus.o_err_port),     32'(m_port));
        chk("perm",         32'(bus.o_perm),         32'(m_perm));
        chk("test_cnt",     32'(bus.o_test_cnt),     32'(m_test));
        chk("err_cnt",      32'(bus.o_err_cnt),      32'(m_err));
        chk("overrun",      32'(bus.o_overrun),      32'(m_ovr));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [23:0] r, input logic gv, input logic [19:0] g);
    bus.i_req_valid   = rv;
    bus.i_req         = r;
    bus.i_grant_valid = gv;
    bus.i_grant       = g;
    sync();
    bus.i_req_valid   = 1'b0;
    bus.i_grant_valid = 1'b0;
  endtask

  task automatic send_req(input logic [23:0] r);
    drive(1'b1, r, 1'b0, 20'h0);
  endtask

  task automatic send_grant(input logic [19:0] g);
    drive(1'b0, 24'h0, 1'b1, g);
  endtask

  task automatic wait_result(input string name, input int g_cyc);
    bit seen;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.o_result_valid) seen = 1;
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
    chk({name, "_latency"}, 32'(cyc - g_cyc), 32'd13);
  endtask

  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.o_result_valid) pulses++;
    end
  endtask

  task automatic run_check(input string name, input logic [23:0] r, input logic [19:0] g,
                           input logic [23:0] e_perm, input logic e_pass, input logic [2:0] e_port);
    int g_cyc;
    send_req(r);
    send_grant(g);
    g_cyc = cyc;
    wait_result(name, g_cyc);
    chk({name, "_perm"}, 32'(bus.o_perm), 32'(e_perm));
    chk({name, "_pass"}, 32'(bus.o_pass), 32'(e_pass));
    chk({name, "_port"}, 32'(bus.o_err_port), 32'(e_port));
    sync();
  endtask

  initial begin
    int pulses;
    int g_cyc;
    bus.i_req = '0; bus.i_req_valid = 1'b0; bus.i_grant = '0; bus.i_grant_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_rv",   32'(bus.o_result_valid), 32'd0);
    chk("rst_perm", 32'(bus.o_perm), 32'd0);
    chk("rst_cnt",  32'({bus.o_test_cnt, bus.o_err_cnt}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_check("ident", 24'hFAC688, 20'h00000, 24'hFAC688, 1'b1, 3'd0);
    chk("ident_test_cnt", 32'(bus.o_test_cnt), 32'd1);
    chk("ident_err_cnt",  32'(bus.o_err_cnt),  32'd0);
    run_check("s4x", 24'hFAC681, 20'h10000, 24'hFAC681, 1'b1, 3'd0);
    run_check("s0x", 24'hFAC681, 20'h00001, 24'hFAC681, 1'b1, 3'd0);
    run_check("bad", 24'hFAC688, 20'h10000, 24'hFAC681, 1'b0, 3'd0);
    chk("bad_err_cnt", 32'(bus.o_err_cnt), 32'd1);

    // A grant with nothing pending is counted as an error and produces no result.
    send_grant(20'h00000);
    count_pulses(16, pulses);
    chk("orphan_pulses",  32'(pulses), 32'd0);
    chk("orphan_err_cnt", 32'(bus.o_err_cnt), 32'd2);
    sync();

    // A second grant during a check is dropped but sets the sticky overrun flag.
    send_req(24'hFAC688);
    send_grant(20'h00000);
    g_cyc = cyc;
    sync();
    sync();
    send_grant(20'h00000);
    wait_result("ovr", g_cyc);
    chk("ovr_flag",     32'(bus.o_overrun),  32'd1);
    chk("ovr_pass",     32'(bus.o_pass),     32'd1);
    chk("ovr_test_cnt", 32'(bus.o_test_cnt), 32'd5);
    chk("ovr_err_cnt",  32'(bus.o_err_cnt),  32'd2);
    sync();

    // A request arriving together with the grant replaces the older pending one.
    send_req(24'hFAC688);
    drive(1'b1, 24'hFAC681, 1'b1, 20'h10000);
    g_cyc = cyc;
    wait_result("same", g_cyc);
    chk("same_pass", 32'(bus.o_pass), 32'd1);
    chk("same_perm", 32'(bus.o_perm), 32'hFAC681);
    sync();

    send_req(24'hFAC688);
    send_grant(20'h00000);
    repeat (6) sync();
    rst = 1'b1;
    sync();
    sync();
    rst = 1'b0;
    count_pulses(20, pulses);
    chk("midrst_pulses", 32'(pulses), 32'd0);
    chk("midrst_cnt",    32'({bus.o_test_cnt, bus.o_err_cnt}), 32'd0);
    chk("midrst_ovr",    32'(bus.o_overrun), 32'd0);
    chk("midrst_busy",   32'(bus.o_busy), 32'd0);
    sync();

    // Preload the error counter at its ceiling, then fail a check.
    @(negedge clk);
    #1;
    force dut.err_cnt_q = 16'hFFFF;
    sat_err_flag = 1'b1;
    #1;
    release dut.err_cnt_q;
    sync();
    sat_err_flag = 1'b0;
    run_check("sat", 24'hFAC688, 20'h10000, 24'hFAC681, 1'b0, 3'd0);
    chk("sat_err_cnt", 32'(bus.o_err_cnt), 32'hFFFF);

    // Preload the test counter at its ceiling so the next completed check wraps it.
    @(negedge clk);
    #1;
    force dut.test_cnt_q = 16'hFFFF;
    wrap_test_flag = 1'b1;
    #1;
    release dut.test_cnt_q;
    sync();
    wrap_test_flag = 1'b0;
    run_check("wrap", 24'hFAC688, 20'h00000, 24'hFAC688, 1'b1, 3'd0);
    chk("wrap_test_cnt", 32'(bus.o_test_cnt), 32'd0);
    send_grant(20'h00000);
    count_pulses(3, pulses);
    chk("sat_orphan_err_cnt", 32'(bus.o_err_cnt), 32'hFFFF);
    sync();

    repeat (3) sync();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ocs_grant_checker.md
Name: ocs_grant_checker

Overview:
Receive-side counterpart of the 8x8 request/grant interface. The block captures each 8-port permutation request (24-bit, 3 bits per input port). It takes the 20-bit switch-setting grant returned by the 8x8 optical controller and traces the grant through the 5-stage Benes fabric, one stage per cycle. It then verifies, one output line per cycle, that the realised permutation matches the request. It reports pass/fail, the realised permutation, the first failing output line, and running test/error counts. It sits beside the controller for self-check in hardware and in the system bench.

Parameters:
P_BAR, 1'b0, grant bit value meaning straight-through (2k->2k, 2k+1->2k+1)
P_CROSS, 1'b1, grant bit value meaning swap (2k<->2k+1)
P_CNTWIDTH, 16, width of test and error counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_req  in  24  request; field [3i+:3] = destination output of input port i
i_req_valid  in  1  one-cycle strobe, captures i_req
i_grant  in  20  switch settings; bit 4s+k = stage s (0..4), switch k (0..3)
i_grant_valid  in  1  one-cycle strobe, starts a check
o_busy  out  1  high from ROUTE entry until return to IDLE
o_result_valid  out  1  one-cycle result strobe
o_pass  out  1  realised permutation equals request; valid with o_result_valid
o_err_port  out  3  lowest mismatching output line; 0 when pass
o_perm  out  24  realised permutation, field [3i+:3] = output reached by input i
o_test_cnt  out  P_CNTWIDTH  completed checks, wraps
o_err_cnt  out  P_CNTWIDTH  failed checks plus orphan grants, saturates at all-ones
o_overrun  out  1  sticky: i_grant_valid seen while busy

Behaviour:
- Reset: all outputs 0; pending-request flag 0; state IDLE. Reset mid-check aborts with no result pulse and no counter update.
- Request slot is one deep. i_req_valid in any state loads the slot and sets pending. A later strobe overwrites the slot. The check in flight uses its own copy taken at start.
- IDLE, i_grant_valid=1, pending=1: copy slot and grant, clear pending, init tag[j]=j (8 lines x 3 bits), go to ROUTE, stage counter=0.
- Simultaneous i_req_valid and i_grant_valid in IDLE: the new request is the one checked.
- IDLE, i_grant_valid=1, pending=0 (orphan grant): no check; o_err_cnt increments (saturating) in the next cycle; o_result_valid stays 0.
- i_grant_valid while not IDLE: ignored; o_overrun <= 1, cleared only by reset.
- ROUTE: each cycle applies stage s. Switch k swaps tags on lines 2k and 2k+1 iff grant bit 4s+k == P_CROSS.
- Inter-stage wiring is applied after the switches in the same cycle:
  - after stage 0: line 2k->k, 2k+1->4+k
  - after stage 1: within each half (base b=0,4), b+2j->b+j, b+2j+1->b+2+j
  - after stage 2: inverse of the stage-1 wiring
  - after stage 3: inverse of the stage-0 wiring
  - after stage 4: none
- ROUTE lasts exactly 5 cycles, then CHECK with line counter j=0.
- CHECK: each cycle examines line j with s=tag[j]:
  - o_perm[3s+:3] <= j
  - mismatch if req_copy[3s+:3] != j; the first mismatch latches o_err_port=j
  - lasts exactly 8 cycles
- On the last CHECK cycle, the same edge:
  - registers o_result_valid=1 and o_pass
  - increments o_test_cnt
  - increments o_err_cnt (saturating) on fail
  - returns to IDLE
- Latency: if i_grant_valid is sampled at edge E0, o_result_valid is sampled high at E14. The next grant is accepted from E14.
- A non-bijective request always fails, since each output line holds exactly one source.
- o_perm, o_pass and o_err_port hold until the next result. o_result_valid is high for exactly 1 cycle.

Decomposition:
- Package ocs_pkg:
  - constants PORTNUM=8, DSTWIDTH=3, STAGENUM=5, SWITCHNUM=4
  - state enum {IDLE, ROUTE, CHECK}
  - tag-vector typedef (8 x 3 bits)
  - function returning the inter-stage wiring for a stage index
- One combinational sub-module, ocs_benes_stage: applies one switch column plus its wiring to the tag vector. It is instantiated once and muxed by the stage counter.

Test Plan:
- Request 0xFAC688 then grant 0x00000 -> E14: o_result_valid=1, o_pass=1, o_perm=0xFAC688, o_test_cnt=1, o_err_cnt=0.
- Request 0xFAC681, grant 0x10000 (stage 4 switch 0 cross) -> o_pass=1, o_perm=0xFAC681. Repeat with grant 0x00001 -> same result.
- Request 0xFAC688, grant 0x10000 -> o_pass=0, o_err_port=0, o_perm=0xFAC681, o_err_cnt=1.
- Grant strobe with no pending request -> no result pulse, o_err_cnt +1. Second grant 3 cycles into a check -> o_overrun=1, first check still completes at E14.
- Request 0xFAC688, then request 0xFAC681 on the same cycle as grant 0x10000 -> pass. Assert rst at cycle 7 of a check -> no pulse, counters 0.
- Counter boundaries: force o_err_cnt to 0xFFFF, then fail a check -> stays 0xFFFF. o_test_cnt at 0xFFFF wraps to 0 after the next completed check.
